// File: rtl/spio_uart_pkg.sv
// spio_uart_pkg: shared types and helpers for the eDVS UART event receiver.
// Bit/event FSM encodings, SpiNNaker header layout and packet builder.
package spio_uart_pkg;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int HDR_PLD = 1;
   localparam int HDR_PAR = 0;

   typedef enum logic [3:0] {
      BS_IDLE,
      BS_START,
      BS_BIT0,
      BS_BIT1,
      BS_BIT2,
      BS_BIT3,
      BS_BIT4,
      BS_BIT5,
      BS_BIT6,
      BS_BIT7,
      BS_STOP
   } bit_state_t;

   typedef enum logic [1:0] {
      EV_SYNC,
      EV_XY,
      EV_TS
   } ev_state_t;

   typedef struct packed {
      logic [31:0] payload;
      logic [31:0] key;
      logic [7:0]  hdr;
   } spin_pkt_t;

   // Parity bit makes the whole 72-bit word carry an odd number of ones.
   function automatic spin_pkt_t build_pkt(
      input logic [31:0] payload,
      input logic [31:0] key,
      input logic        has_pld
   );
      spin_pkt_t p;
      p.payload        = payload;
      p.key            = key;
      p.hdr            = '0;
      p.hdr[HDR_PLD]   = has_pld;
      p.hdr[HDR_PAR]   = ~^{payload, key, p.hdr[7:1]};
      return p;
   endfunction

endpackage

// File: rtl/spio_uart_byte_rx.sv
// spio_uart_byte_rx: oversampled 8N1 receiver, samples each bit mid-way.
// Emits one-cycle byte valid or frame error after the stop-bit sample.
module spio_uart_byte_rx
   import spio_uart_pkg::*;
#(
   parameter int OVERSAMPLE_LOG2 = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       pulse,
   output logic [7:0] data,
   output logic       vld,
   output logic       frame_err,
   output logic       busy
);

   localparam int OS = OVERSAMPLE_LOG2;
   localparam logic [OS-1:0] HALF_M1 = OS'((1 << (OS - 1)) - 1);
   localparam logic [OS-1:0] FULL_M1 = OS'((1 << OS) - 1);

   bit_state_t    state;
   bit_state_t    nxt;
   logic [OS-1:0] phase;
   logic          sample;
   logic          in_data;
   logic          shift_en;
   logic          done_ok;
   logic          done_bad;

   // First sample lands half a bit after start detection, then every bit.
   assign sample  = pulse &&
                    (phase == ((state == BS_START) ? HALF_M1 : FULL_M1));
   assign busy    = (state != BS_IDLE);
   assign in_data = (state >= BS_BIT0) && (state <= BS_BIT7);

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= BS_IDLE;
      else       state <= nxt;

   always_comb begin
      nxt = state;
      unique case (state)
         BS_IDLE:
            if (pulse && rx == START_BIT) nxt = BS_START;
         BS_START:
            if (pulse && rx != START_BIT) nxt = BS_IDLE;
            else if (sample)             nxt = BS_BIT0;
         BS_BIT0, BS_BIT1, BS_BIT2, BS_BIT3,
         BS_BIT4, BS_BIT5, BS_BIT6, BS_BIT7:
            if (sample) nxt = bit_state_t'(state + 4'd1);
         BS_STOP:
            if (sample) nxt = BS_IDLE;
         default:
            nxt = BS_IDLE;
      endcase
   end

   always_comb begin
      shift_en = sample && in_data;
      done_ok  = sample && (state == BS_STOP) && (rx == STOP_BIT);
      done_bad = sample && (state == BS_STOP) && (rx != STOP_BIT);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         phase     <= '0;
         data      <= '0;
         vld       <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         vld       <= done_ok;
         frame_err <= done_bad;
         if (state == BS_IDLE)
            phase <= '0;
         else if (pulse)
            phase <= sample ? '0 : phase + 1'b1;
         if (shift_en)
            data <= {rx, data[7:1]};
      end

endmodule

// File: rtl/spio_uart_fifo.sv
// spio_uart_fifo: ready/valid word FIFO, one slot kept empty.
// Output word reads as zero whenever the FIFO is empty.
module spio_uart_fifo #(
   parameter int WORD_SIZE = 72,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic                 wr_en,
   output logic                 wr_rdy,
   output logic [WORD_SIZE-1:0] rd_data,
   output logic                 rd_vld,
   input  logic                 rd_rdy,
   output logic [ADDR_BITS-1:0] occupancy
);

   logic [WORD_SIZE-1:0] mem [0:(1<<ADDR_BITS)-1];
   logic [ADDR_BITS-1:0] wptr;
   logic [ADDR_BITS-1:0] rptr;
   logic                 wr;
   logic                 rd;

   assign occupancy = wptr - rptr;
   assign wr_rdy    = (occupancy != '1);
   assign rd_vld    = (occupancy != '0);
   assign rd_data   = rd_vld ? mem[rptr] : '0;
   assign wr        = wr_en && wr_rdy;
   assign rd        = rd_vld && rd_rdy;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
      end

   always_ff @(posedge clk)
      if (wr) mem[wptr] <= wr_data;

endmodule

// File: rtl/spio_uart_evt_rx.sv
// spio_uart_evt_rx: eDVS UART event receiver and SpiNNaker packet assembler.
// Bytes -> sync/xy/timestamp events -> buffered 72-bit packets with CTS.
module spio_uart_evt_rx
   import spio_uart_pkg::*;
#(
   parameter int          OVERSAMPLE_LOG2 = 3,
   parameter int          FIFO_ADDR_BITS  = 4,
   parameter int          HIGH_WATER_MARK = 8,
   parameter int          TIMEOUT_BITS    = 32,
   parameter logic [31:0] KEY_BASE        = 32'h0
) (
   input  logic        CLK_IN,
   input  logic        RESET_IN,
   input  logic        RX_IN,
   input  logic        SUBSAMPLE_PULSE_IN,
   input  logic [1:0]  MODE_IN,
   output logic        CTS_OUT,
   output logic [71:0] PKT_DATA_OUT,
   output logic        PKT_VLD_OUT,
   input  logic        PKT_RDY_IN,
   output logic        FRAME_ERR_OUT,
   output logic        SYNC_ERR_OUT,
   output logic        PKT_DROPPED_OUT,
   output logic [15:0] DROP_COUNT_OUT
);

   localparam int LIMIT = TIMEOUT_BITS << OVERSAMPLE_LOG2;
   localparam int TW    = $clog2(LIMIT);
   localparam logic [TW-1:0] LIMIT_M1 = TW'(LIMIT - 1);
   localparam logic [FIFO_ADDR_BITS:0] HWM =
      (FIFO_ADDR_BITS + 1)'(HIGH_WATER_MARK);

   logic [7:0]  rx_byte;
   logic        byte_vld;
   logic        frame_err;
   logic        rx_busy;

   ev_state_t   ev;
   ev_state_t   ev_nxt;
   logic [1:0]  ts_n;
   logic [1:0]  ts_left;
   logic [6:0]  x;
   logic [6:0]  y;
   logic        p;
   logic [31:0] ts;
   logic [TW-1:0] tmo_cnt;
   logic        in_evt;
   logic        tmo;

   logic        ld_y;
   logic        ld_xy;
   logic        ld_ts;
   logic        emit;
   logic        serr;

   logic [6:0]  x_f;
   logic        p_f;
   logic [31:0] ts_f;
   spin_pkt_t   pkt_f;

   logic [71:0] wr_data;
   logic        wr_en;
   logic        wr_rdy;
   logic [FIFO_ADDR_BITS-1:0] occ;

   spio_uart_byte_rx #(
      .OVERSAMPLE_LOG2 (OVERSAMPLE_LOG2)
   ) u_byte_rx (
      .clk       (CLK_IN),
      .reset     (RESET_IN),
      .rx        (RX_IN),
      .pulse     (SUBSAMPLE_PULSE_IN),
      .data      (rx_byte),
      .vld       (byte_vld),
      .frame_err (frame_err),
      .busy      (rx_busy)
   );

   // Timeout only advances on idle-line pulses between bytes.
   assign in_evt = (ev != EV_SYNC);
   assign tmo    = in_evt && SUBSAMPLE_PULSE_IN && !rx_busy &&
                   !byte_vld && (tmo_cnt == LIMIT_M1);

   always_ff @(posedge CLK_IN or posedge RESET_IN)
      if (RESET_IN) ev <= EV_SYNC;
      else          ev <= ev_nxt;

   always_comb begin
      ev_nxt = ev;
      if (frame_err || tmo)
         ev_nxt = EV_SYNC;
      else if (byte_vld)
         unique case (ev)
            EV_SYNC: if (rx_byte[7]) ev_nxt = EV_XY;
            EV_XY:   ev_nxt = (ts_n == 2'd0) ? EV_SYNC : EV_TS;
            EV_TS:   if (ts_left == 2'd1) ev_nxt = EV_SYNC;
            default: ev_nxt = EV_SYNC;
         endcase
   end

   always_comb begin
      ld_y  = byte_vld && (ev == EV_SYNC) && rx_byte[7];
      ld_xy = byte_vld && (ev == EV_XY);
      ld_ts = byte_vld && (ev == EV_TS);
      emit  = (ld_xy && (ts_n == 2'd0)) ||
              (ld_ts && (ts_left == 2'd1));
      serr  = tmo || (byte_vld && (ev == EV_SYNC) && !rx_byte[7]);
   end

   // Packet as it would look if the current byte completes the event.
   always_comb begin
      x_f  = x;
      p_f  = p;
      ts_f = ts;
      if (ev == EV_XY) begin
         x_f  = rx_byte[6:0];
         p_f  = rx_byte[7];
         ts_f = '0;
      end else if (ev == EV_TS) begin
         ts_f = {ts[23:0], rx_byte};
      end
      pkt_f = build_pkt(ts_f,
                        {KEY_BASE[31:15], x_f, y, p_f},
                        (ts_n != 2'd0));
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN)
      if (RESET_IN) begin
         ts_n    <= '0;
         ts_left <= '0;
         x       <= '0;
         y       <= '0;
         p       <= 1'b0;
         ts      <= '0;
         tmo_cnt <= '0;
         wr_en   <= 1'b0;
         wr_data <= '0;
         SYNC_ERR_OUT <= 1'b0;
      end else begin
         wr_en        <= emit;
         SYNC_ERR_OUT <= serr;
         if (emit) wr_data <= pkt_f;
         if (ld_y) begin
            y    <= rx_byte[6:0];
            ts_n <= MODE_IN;
            ts   <= '0;
         end
         if (ld_xy) begin
            x       <= rx_byte[6:0];
            p       <= rx_byte[7];
            ts_left <= ts_n;
         end
         if (ld_ts) begin
            ts      <= {ts[23:0], rx_byte};
            ts_left <= ts_left - 2'd1;
         end
         if (byte_vld || !in_evt || tmo)
            tmo_cnt <= '0;
         else if (SUBSAMPLE_PULSE_IN && !rx_busy)
            tmo_cnt <= tmo_cnt + 1'b1;
      end

   spio_uart_fifo #(
      .WORD_SIZE (72),
      .ADDR_BITS (FIFO_ADDR_BITS)
   ) u_fifo (
      .clk       (CLK_IN),
      .reset     (RESET_IN),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .wr_rdy    (wr_rdy),
      .rd_data   (PKT_DATA_OUT),
      .rd_vld    (PKT_VLD_OUT),
      .rd_rdy    (PKT_RDY_IN),
      .occupancy (occ)
   );

   always_ff @(posedge CLK_IN or posedge RESET_IN)
      if (RESET_IN) begin
         PKT_DROPPED_OUT <= 1'b0;
         DROP_COUNT_OUT  <= '0;
      end else begin
         PKT_DROPPED_OUT <= wr_en && !wr_rdy;
         if (wr_en && !wr_rdy && DROP_COUNT_OUT != 16'hFFFF)
            DROP_COUNT_OUT <= DROP_COUNT_OUT + 16'd1;
      end

   assign FRAME_ERR_OUT = frame_err;
   assign CTS_OUT       = !RESET_IN && ({1'b0, occ} < HWM);

endmodule

// File: tb/tb_spio_uart_evt_rx.sv
// tb_spio_uart_evt_rx: randomized event stimulus against a packet-level model.
// Serial frames are synthesised from bytes; packets are predicted from events.
module tb_spio_uart_evt_rx;

   localparam int          OVS  = 3;
   localparam int          N    = 1 << OVS;
   localparam int          HALF = N / 2;
   localparam int          T    = 32;
   localparam logic [31:0] KB   = 32'h5A5A_F0F0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic        sp  = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        rdy = 1'b0;
   logic        cts;
   logic [71:0] data;
   logic        vld;
   logic        ferr;
   logic        serr;
   logic        drop;
   logic [15:0] dcnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_ferr = 0;
   int n_serr = 0;
   int n_drop = 0;
   int mdrop  = 0;

   logic [71:0] got[$];
   logic [71:0] exp[$];

   spio_uart_evt_rx #(
      .OVERSAMPLE_LOG2 (OVS),
      .FIFO_ADDR_BITS  (4),
      .HIGH_WATER_MARK (8),
      .TIMEOUT_BITS    (T),
      .KEY_BASE        (KB)
   ) dut (
      .CLK_IN             (clk),
      .RESET_IN           (rst),
      .RX_IN              (rx),
      .SUBSAMPLE_PULSE_IN (sp),
      .MODE_IN            (mode),
      .CTS_OUT            (cts),
      .PKT_DATA_OUT       (data),
      .PKT_VLD_OUT        (vld),
      .PKT_RDY_IN         (rdy),
      .FRAME_ERR_OUT      (ferr),
      .SYNC_ERR_OUT       (serr),
      .PKT_DROPPED_OUT    (drop),
      .DROP_COUNT_OUT     (dcnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst) begin
         if (vld && rdy) got.push_back(data);
         if (ferr) n_ferr++;
         if (serr) n_serr++;
         if (drop) n_drop++;
      end

   initial begin
      #2ms;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic [71:0] ref_pkt(
      input logic [6:0] y, input logic [6:0] x, input logic p,
      input logic [1:0] m, input logic [31:0] ts);
      logic [31:0] pl;
      logic [31:0] key;
      logic [7:0]  hdr;
      pl  = (m == 2'd0) ? 32'h0 : ts & (32'hFFFF_FFFF >> (32 - 8 * int'(m)));
      key = {KB[31:15], x, y, p};
      hdr = {6'b0, (m != 2'd0), 1'b0};
      if ($countones({pl, key, hdr}) % 2 == 0) hdr[0] = 1'b1;
      return {pl, key, hdr};
   endfunction

   task automatic pulse(input logic r);
      int gap;
      gap = $urandom_range(2, 1);
      rx = r;
      repeat (gap) begin @(posedge clk); #1; end
      sp = 1'b1;
      @(posedge clk); #1;
      sp = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) pulse(1'b1);
   endtask

   // Ends on the stop-bit sample pulse.
   task automatic send_bits(input logic [7:0] b, input logic stop);
      repeat (N) pulse(1'b0);
      for (int i = 0; i < 8; i++) repeat (N) pulse(b[i]);
      repeat (HALF + 1) pulse(stop);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 1'b1);
      idle(N - HALF - 1 + N);
   endtask

   task automatic send_event(input logic [6:0] y, input logic [6:0] x,
                             input logic p, input logic [1:0] m,
                             input logic [31:0] ts);
      mode = m;
      send_byte({1'b1, y});
      mode = 2'($urandom);
      send_byte({p, x});
      for (int k = int'(m); k > 0; k--) send_byte(ts[8*k-1 -: 8]);
      if (exp.size() - got.size() >= 15) mdrop++;
      else exp.push_back(ref_pkt(y, x, p, m, ts));
   endtask

   task automatic send_rand_event();
      send_event(7'($urandom), 7'($urandom), 1'($urandom),
                 2'($urandom), $urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (cts !== 1'b0) begin n_fail++; $display("FAIL rst_cts got %b want 0", cts); end
      n_cmp++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b want 0", vld); end
      n_cmp++; if (data !== 72'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", data); end
      n_cmp++; if ({ferr, serr, drop} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got %b want 000", {ferr, serr, drop}); end
      n_cmp++; if (dcnt !== 16'h0) begin n_fail++; $display("FAIL rst_dcnt got %h want 0", dcnt); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (cts !== 1'b1) begin n_fail++; $display("FAIL post_rst_cts got %b want 1", cts); end
      n_cmp++; if (vld !== 1'b0) begin n_fail++; $display("FAIL post_rst_vld got %b want 0", vld); end
   endtask

   task automatic test_directed();
      rdy = 1'b1;
      mode = 2'd2;
      send_byte(8'hA5);
      mode = 2'd0;
      send_byte(8'h93);
      send_byte(8'h12);
      send_byte(8'h34);
      n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL dir_count got %0d want 1", got.size()); end
      if (got.size() > 0) begin
         n_cmp++; if (got[0][39:8] !== {KB[31:15], 15'h134B}) begin n_fail++; $display("FAIL dir_key got %h want %h", got[0][39:8], {KB[31:15], 15'h134B}); end
         n_cmp++; if (got[0][71:40] !== 32'h0000_1234) begin n_fail++; $display("FAIL dir_payload got %h want 00001234", got[0][71:40]); end
         n_cmp++; if (got[0][7:1] !== 7'b0000001) begin n_fail++; $display("FAIL dir_hdr got %b want 0000001", got[0][7:1]); end
         n_cmp++; if ($countones(got[0]) % 2 != 1) begin n_fail++; $display("FAIL dir_parity got even want odd (%h)", got[0]); end
      end
      got.delete();
      exp.delete();
   endtask

   task automatic test_latency();
      logic [71:0] e;
      rdy = 1'b1;
      mode = 2'd0;
      send_byte(8'h81);
      send_bits(8'h02, 1'b1);
      e = ref_pkt(7'h01, 7'h02, 1'b0, 2'd0, 32'h0);
      @(posedge clk); #1;
      n_cmp++; if (vld !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1 got %b want 0", vld); end
      @(posedge clk); #1;
      n_cmp++; if (vld !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2 got %b want 1", vld); end
      n_cmp++; if (data !== e) begin n_fail++; $display("FAIL lat_data got %h want %h", data, e); end
      idle(N);
      n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL lat_count got %0d want 1", got.size()); end
      got.delete();
      exp.delete();
   endtask

   task automatic test_sync_err();
      int s0;
      rdy = 1'b1;
      s0 = n_serr;
      send_byte(8'h05);
      send_rand_event();
      n_cmp++; if (n_serr - s0 !== 1) begin n_fail++; $display("FAIL serr_pulses got %0d want 1", n_serr - s0); end
      n_cmp++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL serr_count got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL serr_pkt got %h want %h", got[i], exp[i]); end
      end
      got.delete();
      exp.delete();
   endtask

   task automatic test_frame_err();
      int f0;
      int s0;
      rdy = 1'b1;
      f0 = n_ferr;
      s0 = n_serr;
      mode = 2'd1;
      send_byte(8'h9A);
      send_bits(8'h44, 1'b0);
      idle(N - HALF - 1 + N);
      n_cmp++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", n_ferr - f0); end
      n_cmp++; if (n_serr - s0 !== 0) begin n_fail++; $display("FAIL ferr_serr got %0d want 0", n_serr - s0); end
      n_cmp++; if (got.size() !== 0) begin n_fail++; $display("FAIL ferr_nopkt got %0d want 0", got.size()); end
      send_rand_event();
      n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL ferr_next_count got %0d want 1", got.size()); end
      if (got.size() == 1) begin
         n_cmp++; if (got[0] !== exp[0]) begin n_fail++; $display("FAIL ferr_next_pkt got %h want %h", got[0], exp[0]); end
      end
      got.delete();
      exp.delete();
   endtask

   task automatic test_timeout();
      int s0;
      logic [71:0] e;
      rdy = 1'b1;
      s0 = n_serr;
      mode = 2'd0;
      send_bits(8'hC4, 1'b1);
      idle((T - 1) * N);
      send_byte(8'h11);
      e = ref_pkt(7'h44, 7'h11, 1'b0, 2'd0, 32'h0);
      n_cmp++; if (n_serr - s0 !== 0) begin n_fail++; $display("FAIL tmo_early got %0d want 0", n_serr - s0); end
      n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL tmo_early_pkt got %0d want 1", got.size()); end
      if (got.size() == 1) begin
         n_cmp++; if (got[0] !== e) begin n_fail++; $display("FAIL tmo_early_data got %h want %h", got[0], e); end
      end
      send_bits(8'h81, 1'b1);
      idle(T * N - 1);
      @(posedge clk); #1;
      n_cmp++; if (n_serr - s0 !== 0) begin n_fail++; $display("FAIL tmo_edge_minus1 got %0d want 0", n_serr - s0); end
      idle(1);
      n_cmp++; if (serr !== 1'b1) begin n_fail++; $display("FAIL tmo_expiry got %b want 1", serr); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (n_serr - s0 !== 1) begin n_fail++; $display("FAIL tmo_pulses got %0d want 1", n_serr - s0); end
      send_byte(8'h02);
      n_cmp++; if (n_serr - s0 !== 2) begin n_fail++; $display("FAIL tmo_in_sync got %0d want 2", n_serr - s0); end
      n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL tmo_nopkt got %0d want 1", got.size()); end
      got.delete();
      exp.delete();
   endtask

   task automatic test_back_to_back();
      rdy = 1'b1;
      for (int e = 0; e < 8; e++) send_rand_event();
      n_cmp++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_pkt%0d got %h want %h", i, got[i], exp[i]); end
      end
      got.delete();
      exp.delete();
   endtask

   task automatic test_fifo_full();
      int d0;
      int s0;
      rdy = 1'b0;
      mdrop = 0;
      d0 = n_drop;
      for (int e = 0; e < 16; e++) begin
         send_rand_event();
         n_cmp++;
         if (cts !== ((exp.size() < 8) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL full_cts ev%0d got %b want %b", e, cts, exp.size() < 8);
         end
      end
      n_cmp++; if (dcnt !== 16'(mdrop)) begin n_fail++; $display("FAIL full_dcnt got %0d want %0d", dcnt, mdrop); end
      n_cmp++; if (n_drop - d0 !== 1) begin n_fail++; $display("FAIL full_drop_pulses got %0d want 1", n_drop - d0); end
      n_cmp++; if (vld !== 1'b1) begin n_fail++; $display("FAIL full_vld got %b want 1", vld); end
      n_cmp++; if (data !== exp[0]) begin n_fail++; $display("FAIL full_hold got %h want %h", data, exp[0]); end
      rdy = 1'b1;
      repeat (24) @(posedge clk);
      #1;
      n_cmp++; if (got.size() !== 15) begin n_fail++; $display("FAIL full_stored got %0d want 15", got.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL full_pkt%0d got %h want %h", i, got[i], exp[i]); end
      end
      got.delete();
      exp.delete();
      rdy = 1'b0;
      for (int e = 0; e < 3; e++) send_rand_event();
      mode = 2'd1;
      send_byte(8'h9F);
      repeat (N) pulse(1'b0);
      repeat (3) pulse(1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got %b want 0", vld); end
      n_cmp++; if (data !== 72'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", data); end
      n_cmp++; if (cts !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cts got %b want 0", cts); end
      n_cmp++; if (dcnt !== 16'h0) begin n_fail++; $display("FAIL mid_rst_dcnt got %h want 0", dcnt); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (cts !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cts_after got %b want 1", cts); end
      got.delete();
      exp.delete();
      rdy = 1'b1;
      s0 = n_serr;
      send_byte(8'h13);
      n_cmp++; if (n_serr - s0 !== 1) begin n_fail++; $display("FAIL mid_rst_needs_sync got %0d want 1", n_serr - s0); end
      send_rand_event();
      n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL mid_rst_next_count got %0d want 1", got.size()); end
      if (got.size() == 1) begin
         n_cmp++; if (got[0] !== exp[0]) begin n_fail++; $display("FAIL mid_rst_next_pkt got %h want %h", got[0], exp[0]); end
      end
      got.delete();
      exp.delete();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latency();
      test_sync_err();
      test_frame_err();
      test_timeout();
      test_back_to_back();
      test_fifo_full();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
